// File: rtl/vicii_bus_sequencer.sv
// VIC-II bus sequencer: 32-tick phase counter driving clk_phi, AEC/BA steal handshake, DRAM strobes, bus enables, register strobes.
// All outputs registered (value for phase p shown while phase == p); BUS_TURNAROUND_EN ends drive windows one tick early.
module vicii_bus_sequencer (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       rw,
  input  logic       vic_p1_req,
  input  logic       steal_req,
  output logic       clk_phi,
  output logic [4:0] phase,
  output logic       aec,
  output logic       ba,
  output logic       ras,
  output logic       cas,
  output logic       addr_col,
  output logic       vic_write_ab,
  output logic       vic_write_db,
  output logic       ls245_dir,
  output logic       stolen,
  output logic       reg_rd,
  output logic       reg_wr
);

`ifdef BUS_TURNAROUND_EN
  localparam logic [3:0] AB_LAST = 4'd13;
  localparam logic [4:0] DB_LAST = 5'd30;
`else
  localparam logic [3:0] AB_LAST = 4'd14;
  localparam logic [4:0] DB_LAST = 5'd31;
`endif

  logic [4:0] phase_q, phase_d;
  logic [1:0] sc_q, sc_d;
  logic       p1_req_q, p1_req_d;
  logic       ba_q, ba_d;
  logic       stolen_q, stolen_d;
  logic       rd_cyc_q, rd_cyc_d;
  logic       wr_cyc_q, wr_cyc_d;
  logic       clk_phi_q, clk_phi_d;
  logic       aec_q, aec_d;
  logic       ras_q, ras_d;
  logic       cas_q, cas_d;
  logic       addr_col_q, addr_col_d;
  logic       ab_q, ab_d;
  logic       db_q, db_d;
  logic       dir_q, dir_d;
  logic       reg_rd_q, reg_rd_d;
  logic       reg_wr_q, reg_wr_d;
  logic [3:0] off;
  logic       acc;

  always_comb begin
    phase_d  = phase_q + 5'd1;
    off      = phase_d[3:0];
    p1_req_d = p1_req_q;
    ba_d     = ba_q;
    sc_d     = sc_q;
    stolen_d = stolen_q;
    rd_cyc_d = rd_cyc_q;
    wr_cyc_d = wr_cyc_q;

    if (phase_q == 5'd31) begin
      p1_req_d = vic_p1_req;
      stolen_d = 1'b0;
      rd_cyc_d = 1'b0;
      wr_cyc_d = 1'b0;
    end

    // Steal decision is made once per cycle, on the phi1->phi2 boundary.
    if (phase_q == 5'd15) begin
      if (!steal_req) begin
        ba_d     = 1'b1;
        sc_d     = 2'd0;
        stolen_d = 1'b0;
      end else if (ba_q) begin
        ba_d     = 1'b0;
        sc_d     = 2'd0;
        stolen_d = 1'b0;
      end else begin
        if (sc_q != 2'd3) sc_d = sc_q + 2'd1;
        stolen_d = (sc_q >= 2'd2);
      end
    end

    if (phase_q == 5'd19) begin
      rd_cyc_d = !ce && rw && !stolen_q;
      wr_cyc_d = !ce && !rw && !stolen_q;
    end

    acc        = phase_d[4] ? stolen_d : p1_req_d;
    clk_phi_d  = phase_d[4];
    aec_d      = phase_d[4] && !stolen_d;
    ab_d       = acc && (off <= AB_LAST);
    addr_col_d = acc && (off >= 4'd7);
    ras_d      = !(acc && (off >= 4'd4) && (off <= 4'd14));
    cas_d      = !(acc && (off >= 4'd9) && (off <= 4'd14));
    reg_rd_d   = rd_cyc_d && (phase_d == 5'd20);
    reg_wr_d   = wr_cyc_d && (phase_d == 5'd28);
    dir_d      = rd_cyc_d && (phase_d >= 5'd21);
    db_d       = rd_cyc_d && (phase_d >= 5'd21) && (phase_d <= DB_LAST);
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= 5'd0;
      sc_q       <= 2'd0;
      p1_req_q   <= 1'b0;
      ba_q       <= 1'b1;
      stolen_q   <= 1'b0;
      rd_cyc_q   <= 1'b0;
      wr_cyc_q   <= 1'b0;
      clk_phi_q  <= 1'b0;
      aec_q      <= 1'b1;
      ras_q      <= 1'b1;
      cas_q      <= 1'b1;
      addr_col_q <= 1'b0;
      ab_q       <= 1'b0;
      db_q       <= 1'b0;
      dir_q      <= 1'b0;
      reg_rd_q   <= 1'b0;
      reg_wr_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      sc_q       <= sc_d;
      p1_req_q   <= p1_req_d;
      ba_q       <= ba_d;
      stolen_q   <= stolen_d;
      rd_cyc_q   <= rd_cyc_d;
      wr_cyc_q   <= wr_cyc_d;
      clk_phi_q  <= clk_phi_d;
      aec_q      <= aec_d;
      ras_q      <= ras_d;
      cas_q      <= cas_d;
      addr_col_q <= addr_col_d;
      ab_q       <= ab_d;
      db_q       <= db_d;
      dir_q      <= dir_d;
      reg_rd_q   <= reg_rd_d;
      reg_wr_q   <= reg_wr_d;
    end
  end

  assign phase        = phase_q;
  assign clk_phi      = clk_phi_q;
  assign aec          = aec_q;
  assign ba           = ba_q;
  assign ras          = ras_q;
  assign cas          = cas_q;
  assign addr_col     = addr_col_q;
  assign vic_write_ab = ab_q;
  assign vic_write_db = db_q;
  assign ls245_dir    = dir_q;
  assign stolen       = stolen_q;
  assign reg_rd       = reg_rd_q;
  assign reg_wr       = reg_wr_q;

endmodule

// File: tb/tb_vicii_bus_sequencer.sv
// Bench for vicii_bus_sequencer: randomized and directed stimulus against a cycle-level reference model.
module tb_vicii_bus_sequencer;

`ifdef BUS_TURNAROUND_EN
  localparam int AB_LAST = 13;
  localparam int DB_LAST = 30;
`else
  localparam int AB_LAST = 14;
  localparam int DB_LAST = 31;
`endif

  logic       clk_dot4x = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b1;
  logic       rw = 1'b1;
  logic       vic_p1_req = 1'b0;
  logic       steal_req = 1'b0;
  logic       clk_phi, aec, ba, ras, cas, addr_col;
  logic       vic_write_ab, vic_write_db, ls245_dir, stolen, reg_rd, reg_wr;
  logic [4:0] phase;

  int checks = 0;
  int errors = 0;

  // Reference model: phase number, latched phi1 request, run length of
  // consecutive steal_req samples, and this cycle's CPU access kind.
  int m_phase = 0;
  int m_run   = 0;
  bit m_p1    = 0;
  bit m_rd    = 0;
  bit m_wr    = 0;
  bit m_rst   = 1;

  always #5 clk_dot4x = ~clk_dot4x;

  vicii_bus_sequencer dut (
    .clk_dot4x   (clk_dot4x),
    .rst_n       (rst_n),
    .ce          (ce),
    .rw          (rw),
    .vic_p1_req  (vic_p1_req),
    .steal_req   (steal_req),
    .clk_phi     (clk_phi),
    .phase       (phase),
    .aec         (aec),
    .ba          (ba),
    .ras         (ras),
    .cas         (cas),
    .addr_col    (addr_col),
    .vic_write_ab(vic_write_ab),
    .vic_write_db(vic_write_db),
    .ls245_dir   (ls245_dir),
    .stolen      (stolen),
    .reg_rd      (reg_rd),
    .reg_wr      (reg_wr)
  );

  function automatic logic [16:0] obs();
    return {phase, clk_phi, aec, ba, ras, cas, addr_col,
            vic_write_ab, vic_write_db, ls245_dir, stolen, reg_rd, reg_wr};
  endfunction

  function automatic logic [16:0] expv();
    int  off;
    bit  phi2, st, acc;
    logic [4:0] ph;
    if (m_rst) return {5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 7'b0};
    off  = m_phase % 16;
    phi2 = (m_phase >= 16);
    st   = phi2 && (m_run >= 4);
    acc  = phi2 ? st : m_p1;
    ph   = 5'(m_phase);
    return {ph, phi2, phi2 && !st, (m_run == 0),
            !(acc && off >= 4 && off <= 14),
            !(acc && off >= 9 && off <= 14),
            acc && off >= 7,
            acc && off <= AB_LAST,
            m_rd && m_phase >= 21 && m_phase <= DB_LAST,
            m_rd && m_phase >= 21,
            st,
            m_rd && m_phase == 20,
            m_wr && m_phase == 28};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_p1 = 0; m_rd = 0; m_wr = 0; m_rst = 1;
  endtask

  // Advance one tick: model consumes the inputs seen at the edge; return at negedge.
  task automatic step();
    int p;
    @(posedge clk_dot4x);
    if (!rst_n) begin
      model_reset();
    end else begin
      p = m_phase;
      m_rst = 0;
      m_phase = (p + 1) % 32;
      if (p == 31) m_p1 = vic_p1_req;
      if (p == 15) m_run = steal_req ? ((m_run < 8) ? m_run + 1 : 8) : 0;
      if (p == 19) begin
        m_rd = !ce && rw && (m_run < 4);
        m_wr = !ce && !rw && (m_run < 4);
      end
    end
    @(negedge clk_dot4x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL reset_async got %h want %h", obs(), expv());
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL reset_held got %h want %h", obs(), expv());
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 64; i++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL idle ph=%0d got %h want %h", m_phase, obs(), expv());
      end
    end
  endtask

  task automatic test_p1_access();
    vic_p1_req = 1'b1;
    for (int i = 0; i < 96; i++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL p1_access ph=%0d got %h want %h", m_phase, obs(), expv());
      end
    end
    vic_p1_req = 1'b0;
  endtask

  task automatic test_cpu_access();
    for (int c = 0; c < 8; c++) begin
      ce = (c % 4) >= 2;
      rw = (c % 2) == 0;
      for (int i = 0; i < 32; i++) begin
        step();
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL cpu_access ce=%0b rw=%0b ph=%0d got %h want %h", ce, rw, m_phase, obs(), expv());
        end
      end
    end
    ce = 1'b1;
    rw = 1'b1;
  endtask

  task automatic run_checked(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL %s ph=%0d run=%0d got %h want %h", name, m_phase, m_run, obs(), expv());
      end
    end
  endtask

  task automatic test_steal();
    int guard = 0;
    while (m_phase != 14 && guard < 64) begin
      step();
      guard++;
    end
    checks++;
    if (m_phase != 14) begin
      errors++;
      $display("FAIL steal_align got phase %0d want 14", m_phase);
    end
    ce = 1'b0;
    rw = 1'b1;
    steal_req = 1'b1;
    run_checked(5 * 32, "steal_hold");
    steal_req = 1'b0;
    run_checked(32, "steal_drop");
    steal_req = 1'b1;
    run_checked(5 * 32, "steal_reassert");
    ce = 1'b1;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    steal_req = 1'b1;
    vic_p1_req = 1'b1;
    while (!(m_phase == 24 && m_run >= 4) && guard < 400) begin
      step();
      guard++;
    end
    checks++;
    if (!(m_phase == 24 && m_run >= 4)) begin
      errors++;
      $display("FAIL reset_mid_reach got phase %0d run %0d want phase 24 stolen", m_phase, m_run);
    end
    checks++;
    if (stolen !== 1'b1 || ras !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pre stolen=%0b ras=%0b want 1 0", stolen, ras);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL reset_mid_async got %h want %h", obs(), expv());
    end
    step();
    rst_n = 1'b1;
    run_checked(160, "reset_mid_after");
    steal_req = 1'b0;
    vic_p1_req = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      vic_p1_req = 1'($urandom_range(0, 1));
      ce = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      if (m_phase == 0 && $urandom_range(0, 5) == 0) steal_req = ~steal_req;
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random ph=%0d run=%0d got %h want %h", m_phase, m_run, obs(), expv());
      end
    end
  endtask

  initial begin
    @(negedge clk_dot4x);
    test_reset();
    test_idle();
    test_p1_access();
    test_cpu_access();
    test_steal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
